// File: rtl/logic_gate_pkg.sv
// Shared opcodes, FSM state type and zero constants for the vector logic-gate sequencer.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        INPUT_STATE     = 2'd1,
        OPERATION_STATE = 2'd2
    } state_t;

    localparam logic [63:0] ZERO_DATA    = '0;
    localparam logic [63:0] ZERO_CONTROL = '0;

    // Unary opcodes complete their operand pair on A alone.
    function automatic logic op_uses_b(input logic [2:0] op);
        return !(op == OP_NOT || op == OP_BUF);
    endfunction

endpackage

// File: rtl/logic_gate_element.sv
// Combinational bitwise opcode mux over one operand pair.
module logic_gate_element
    import logic_gate_pkg::*;
#(
    parameter int DATA_SIZE = 64
) (
    input  logic [2:0]           op,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_BUF:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_logic_gate.sv
// Sequences a vector of operand pairs through one bitwise gate, one registered result per element.
module vector_logic_gate
    import logic_gate_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [2:0]              OPERATION_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic                    DATA_ENABLE,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [CONTROL_SIZE-1:0] size_q, size_d;
    logic [CONTROL_SIZE-1:0] index_q, index_d;
    logic [DATA_SIZE-1:0]    a_q, a_d;
    logic [DATA_SIZE-1:0]    b_q, b_d;
    logic                    a_valid_q, a_valid_d;
    logic                    b_valid_q, b_valid_d;
    logic                    de_pend_q, de_pend_d;
    logic                    ready_q, ready_d;
    logic                    de_q, de_d;
    logic                    doe_q, doe_d;
    logic [DATA_SIZE-1:0]    dout_q, dout_d;
    logic [DATA_SIZE-1:0]    gate_y;

    logic_gate_element #(
        .DATA_SIZE(DATA_SIZE)
    ) u_gate (
        .op(op_q),
        .a (a_q),
        .b (b_q),
        .y (gate_y)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        size_d    = size_q;
        index_d   = index_q;
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        dout_d    = dout_q;
        de_pend_d = 1'b0;
        ready_d   = 1'b0;
        de_d      = 1'b0;
        doe_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d      = OPERATION_IN;
                    size_d    = SIZE_IN;
                    index_d   = CONTROL_SIZE'(ZERO_CONTROL);
                    a_valid_d = 1'b0;
                    b_valid_d = 1'b0;
                    if (SIZE_IN == CONTROL_SIZE'(ZERO_CONTROL)) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = INPUT_STATE;
                        de_d    = 1'b1;
                    end
                end
            end
            INPUT_STATE: begin
                // Request for the next pair is delayed one cycle behind the previous result.
                de_d = de_pend_q;
                if (DATA_A_IN_ENABLE && !a_valid_q) begin
                    a_d       = DATA_A_IN;
                    a_valid_d = 1'b1;
                end
                if (DATA_B_IN_ENABLE && !b_valid_q) begin
                    b_d       = DATA_B_IN;
                    b_valid_d = 1'b1;
                end
                if (a_valid_d && (b_valid_d || !op_uses_b(op_q))) begin
                    state_d = OPERATION_STATE;
                end
            end
            OPERATION_STATE: begin
                dout_d    = gate_y;
                doe_d     = 1'b1;
                a_valid_d = 1'b0;
                b_valid_d = 1'b0;
                if (index_q == size_q - CONTROL_SIZE'(1)) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    index_d   = index_q + CONTROL_SIZE'(1);
                    de_pend_d = 1'b1;
                    state_d   = INPUT_STATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            op_q      <= OP_AND;
            size_q    <= CONTROL_SIZE'(ZERO_CONTROL);
            index_q   <= CONTROL_SIZE'(ZERO_CONTROL);
            a_q       <= DATA_SIZE'(ZERO_DATA);
            b_q       <= DATA_SIZE'(ZERO_DATA);
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            de_pend_q <= 1'b0;
            ready_q   <= 1'b0;
            de_q      <= 1'b0;
            doe_q     <= 1'b0;
            dout_q    <= DATA_SIZE'(ZERO_DATA);
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            size_q    <= size_d;
            index_q   <= index_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            de_pend_q <= de_pend_d;
            ready_q   <= ready_d;
            de_q      <= de_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
        end
    end

    assign READY           = ready_q;
    assign DATA_ENABLE     = de_q;
    assign DATA_OUT_ENABLE = doe_q;
    assign DATA_OUT        = dout_q;

endmodule

// File: tb/tb_vector_logic_gate.sv
// Scoreboard bench for vector_logic_gate with DATA_SIZE=8 and directed operand vectors.
module tb_vector_logic_gate;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          READY;
    logic [2:0]    OPERATION_IN;
    logic [CW-1:0] SIZE_IN;
    logic          DATA_A_IN_ENABLE;
    logic          DATA_B_IN_ENABLE;
    logic [DW-1:0] DATA_A_IN;
    logic [DW-1:0] DATA_B_IN;
    logic          DATA_ENABLE;
    logic          DATA_OUT_ENABLE;
    logic [DW-1:0] DATA_OUT;

    vector_logic_gate #(
        .DATA_SIZE   (DW),
        .CONTROL_SIZE(CW)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .START           (START),
        .READY           (READY),
        .OPERATION_IN    (OPERATION_IN),
        .SIZE_IN         (SIZE_IN),
        .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE),
        .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
        .DATA_A_IN       (DATA_A_IN),
        .DATA_B_IN       (DATA_B_IN),
        .DATA_ENABLE     (DATA_ENABLE),
        .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
        .DATA_OUT        (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          doe;
        logic          rdy;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   de_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_elem(input logic [DW-1:0] data, input logic last);
        exp_t e;
        e.doe = 1'b1;
        e.rdy = last;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (DATA_ENABLE === 1'b1) de_count++;
        if (DATA_OUT_ENABLE === 1'b1 || READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, DATA_OUT_ENABLE, READY}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_enable", {31'd0, DATA_OUT_ENABLE}, {31'd0, e.doe});
                check("ready", {31'd0, READY}, {31'd0, e.rdy});
                if (e.doe) check("data_out", {24'd0, DATA_OUT}, {24'd0, e.data});
            end
        end
    end

    task automatic do_start(input logic [2:0] op, input logic [CW-1:0] size);
        @(negedge CLK);
        START = 1'b1;
        OPERATION_IN = op;
        SIZE_IN = size;
        @(negedge CLK);
        START = 1'b0;
        OPERATION_IN = 3'($urandom);
        SIZE_IN = CW'($urandom);
    endtask

    task automatic pulse(input logic a_en, input logic [DW-1:0] a, input logic b_en, input logic [DW-1:0] b);
        DATA_A_IN_ENABLE = a_en;
        DATA_A_IN = a;
        DATA_B_IN_ENABLE = b_en;
        DATA_B_IN = b;
        @(negedge CLK);
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
    endtask

    task automatic wait_de();
        for (int i = 0; i < 20 && DATA_ENABLE !== 1'b1; i++) @(negedge CLK);
        check("data_enable_wait", {31'd0, DATA_ENABLE}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        check("scoreboard_drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] xa[3] = '{8'hFF, 8'hAA, 8'h12};
    logic [DW-1:0] xb[3] = '{8'h0F, 8'h55, 8'h12};
    logic [DW-1:0] xr[3] = '{8'hF0, 8'hFF, 8'h00};

    initial begin
        RST = 1'b1;
        START = 1'b1;
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
        // Reset with random inputs and START held high.
        for (int i = 0; i < 2; i++) begin
            OPERATION_IN = 3'($urandom);
            SIZE_IN = CW'($urandom_range(1, 5));
            DATA_A_IN_ENABLE = 1'($urandom);
            DATA_B_IN_ENABLE = 1'($urandom);
            DATA_A_IN = DW'($urandom);
            DATA_B_IN = DW'($urandom);
            @(negedge CLK);
            check("rst_ready", {31'd0, READY}, 32'd0);
            check("rst_data_enable", {31'd0, DATA_ENABLE}, 32'd0);
            check("rst_out_enable", {31'd0, DATA_OUT_ENABLE}, 32'd0);
            check("rst_data_out", {24'd0, DATA_OUT}, 32'd0);
        end
        RST = 1'b0;
        START = 1'b0;
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
        de_count = 0;
        repeat (3) @(negedge CLK);
        check("rst_start_ignored", de_count, 32'd0);

        // NOR size 1, both operands in the same cycle; exact latency checked.
        expect_elem(8'hC0, 1'b1);
        do_start(3'd4, 16'd1);
        check("nor_de_after_start", {31'd0, DATA_ENABLE}, 32'd1);
        pulse(1'b1, 8'h0F, 1'b1, 8'h30);
        check("nor_latency_early", {31'd0, DATA_OUT_ENABLE}, 32'd0);
        @(negedge CLK);
        check("nor_latency_2cyc", {31'd0, DATA_OUT_ENABLE}, 32'd1);
        drain();

        // XOR size 3, B lagging A by two cycles.
        de_count = 0;
        for (int i = 0; i < 3; i++) expect_elem(xr[i], i == 2);
        do_start(3'd2, 16'd3);
        for (int i = 0; i < 3; i++) begin
            wait_de();
            pulse(1'b1, xa[i], 1'b0, 8'h00);
            @(negedge CLK);
            pulse(1'b0, 8'h00, 1'b1, xb[i]);
        end
        drain();
        repeat (3) @(negedge CLK);
        check("xor_de_count", de_count, 32'd3);

        // NOT size 1, B never asserted, late duplicate A ignored.
        expect_elem(8'h5A, 1'b1);
        do_start(3'd6, 16'd1);
        pulse(1'b1, 8'hA5, 1'b0, 8'hEE);
        pulse(1'b1, 8'h00, 1'b0, 8'hEE);
        drain();

        // First capture wins: duplicate A while waiting for B (XNOR).
        expect_elem(8'hF0, 1'b1);
        do_start(3'd5, 16'd1);
        pulse(1'b1, 8'h3C, 1'b0, 8'h00);
        pulse(1'b1, 8'hFF, 1'b0, 8'h00);
        pulse(1'b0, 8'h00, 1'b1, 8'h33);
        drain();

        // Zero-length vector: READY only.
        de_count = 0;
        begin
            exp_t e;
            e.doe = 1'b0;
            e.rdy = 1'b1;
            e.data = '0;
            exp_q.push_back(e);
        end
        do_start(3'd1, 16'd0);
        drain();
        repeat (3) @(negedge CLK);
        check("size0_no_de", de_count, 32'd0);

        // AND size 4 aborted by reset after the first result.
        expect_elem(8'h30, 1'b0);
        do_start(3'd0, 16'd4);
        pulse(1'b1, 8'hF0, 1'b1, 8'h3C);
        drain();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        de_count = 0;
        check("abort_data_out", {24'd0, DATA_OUT}, 32'd0);
        check("abort_out_enable", {31'd0, DATA_OUT_ENABLE}, 32'd0);
        repeat (4) @(negedge CLK);
        check("abort_no_de", de_count, 32'd0);

        // Fresh OR vector after the abort.
        expect_elem(8'h03, 1'b1);
        do_start(3'd1, 16'd1);
        pulse(1'b1, 8'h01, 1'b1, 8'h02);
        drain();
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_logic_gate.md
# vector_logic_gate

Vector-level sequencer for the bitwise logic-gate elements of the NTM computing/information path. It accepts a vector of SIZE_IN operand pairs from the upstream controller through per-operand enable strobes. It applies one selected bitwise operation (AND/OR/XOR/NAND/NOR/XNOR/NOT/BUF) to each pair, emits one registered result per element, and signals vector completion to the downstream stage.

## Interface
Parameters:
- DATA_SIZE, 64, width of each vector element.
- CONTROL_SIZE, 64, width of the vector-length field and the element counter.

Ports:
- CLK  in  1  clock; everything samples on its rising edge.
- RST  in  1  reset. Synchronous, active-high: sampled on the rising CLK edge, RST==1 resets.
- START  in  1  begins a vector; sampled only in IDLE.
- READY  out  1  one-cycle pulse when the vector completes.
- OPERATION_IN  in  3  operation select; latched at START.
- SIZE_IN  in  CONTROL_SIZE  number of elements; latched at START.
- DATA_A_IN_ENABLE  in  1  DATA_A_IN valid this cycle.
- DATA_B_IN_ENABLE  in  1  DATA_B_IN valid this cycle.
- DATA_A_IN  in  DATA_SIZE  operand A element.
- DATA_B_IN  in  DATA_SIZE  operand B element.
- DATA_ENABLE  out  1  one-cycle pulse requesting the next element pair from upstream.
- DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT valid.
- DATA_OUT  out  DATA_SIZE  result element.

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 BUF A. All operations are bitwise over DATA_SIZE bits, with no width change.
- FSM states: IDLE, INPUT_STATE, OPERATION_STATE.
- IDLE:
  - On START, latch OPERATION_IN and SIZE_IN, clear the element index, and clear the a_valid/b_valid flags.
  - If SIZE_IN==0: stay in IDLE and pulse READY next cycle. No DATA_OUT_ENABLE.
  - Otherwise: go to INPUT_STATE and pulse DATA_ENABLE next cycle.
- INPUT_STATE:
  - DATA_A_IN_ENABLE captures DATA_A_IN and sets a_valid. DATA_B_IN_ENABLE does the same for B and b_valid.
  - A and B may arrive in the same cycle or in any order and separation.
  - An enable on an operand whose flag is already set is ignored; the first capture wins.
  - The pair is complete when a_valid and b_valid are both set. For opcodes 6 and 7, a_valid alone completes the pair and B is don't-care.
  - On pair complete, go to OPERATION_STATE.
- OPERATION_STATE:
  - Register DATA_OUT = op(A,B), pulse DATA_OUT_ENABLE, and clear both flags.
  - If index == size−1: pulse READY together with DATA_OUT_ENABLE and return to IDLE.
  - Otherwise: increment the index, pulse DATA_ENABLE in the next cycle, and return to INPUT_STATE.
  - Operand enables arriving in OPERATION_STATE are ignored.
- START outside IDLE is ignored. OPERATION_IN and SIZE_IN changes mid-vector have no effect.
- DATA_OUT holds its last value between DATA_OUT_ENABLE pulses.

## Timing
- Reset values: READY=0, DATA_ENABLE=0, DATA_OUT_ENABLE=0, DATA_OUT=0. Internally: state IDLE, index=0, flags cleared.
- RST mid-vector aborts at that edge. No READY is issued for the aborted vector. A START one cycle after RST deasserts is accepted.
- Latency: the edge that completes the pair enters OPERATION_STATE. DATA_OUT and DATA_OUT_ENABLE become valid after the following edge, i.e. 2 cycles from pair-complete sampling.
- DATA_ENABLE rises 1 cycle after the START edge, and 1 cycle after each non-final DATA_OUT_ENABLE.
- Minimum throughput is one element per 3 cycles. Each pulse output is exactly one cycle wide.
- Index wrap cannot occur: the counter is CONTROL_SIZE wide, and termination compares against the latched size−1.

## Structure
- logic_gate_pkg holds:
  - opcode localparams (OP_AND … OP_BUF);
  - FSM state enum (IDLE, INPUT_STATE, OPERATION_STATE);
  - ZERO_DATA / ZERO_CONTROL constants.
- One sub-module, logic_gate_element: a purely combinational, DATA_SIZE-parameterised opcode mux over A and B. It is instantiated once, and its output is registered in vector_logic_gate.
- Target size is 150–250 RTL lines total.

## Test plan
Benches use DATA_SIZE=8.
- Reset: hold RST=1 for 2 cycles with random inputs → all outputs 0. START during RST does not start a vector.
- NOR, size 1: A=0x0F and B=0x30 in the same cycle → DATA_OUT=0xC0 with DATA_OUT_ENABLE 2 cycles later. READY pulses in the same cycle as DATA_OUT_ENABLE.
- XOR, size 3, B lagging A by 2 cycles, pairs (0xFF,0x0F), (0xAA,0x55), (0x12,0x12):
  - outputs are 0xF0, 0xFF, 0x00;
  - DATA_ENABLE pulses 3 times;
  - READY pulses only with the third output.
- NOT, size 1, B never asserted: A=0xA5 → DATA_OUT=0x5A. A duplicate A enable of 0x00 in the same INPUT_STATE is ignored.
- SIZE_IN=0 START → READY pulses 1 cycle later, with no DATA_ENABLE and no DATA_OUT_ENABLE.
- Size 4 AND: after the first output, assert RST for 1 cycle → outputs 0 and no READY. A new size-1 OR START with (0x01,0x02) then yields 0x03.
